// File: rtl/controle_display.sv
// Shared binary-to-BCD conversion controller for the data and program-counter
// 7-segment displays: arbitrates one sequential double-dabble engine.
module controle_display #(
  parameter int DIGITOS   = 8,
  parameter int BITS_CONV = 27
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   out,
  input  logic                   in,
  input  logic [31:0]            dados,
  input  logic [31:0]            entrada,
  input  logic [31:0]            endereco,
  output logic [4*DIGITOS-1:0]   segmentos,
  output logic [4*DIGITOS-1:0]   segmentosPrograma,
  output logic [31:0]            saida,
  output logic                   neg,
  output logic                   estouro,
  output logic                   estouroPrograma,
  output logic                   ocupado,
  output logic                   pronto
);

  localparam int          BCD_W  = 4 * DIGITOS;
  localparam int          CNT_W  = $clog2(BITS_CONV);
  localparam logic [31:0] LIMITE = 32'd99_999_999;

  typedef enum logic [1:0] {OCIOSO, CONVERTE, GRAVA} estado_t;
  typedef enum logic [1:0] {SRC_OUT, SRC_IN, SRC_PC} fonte_t;

  estado_t              state_reg, state_next;
  fonte_t               fonte_reg, fonte_next;
  logic                 pend_out_reg, pend_out_next;
  logic                 pend_in_reg, pend_in_next;
  logic [31:0]          op_out_reg, op_out_next;
  logic [31:0]          op_in_reg, op_in_next;
  logic                 pc_valido_reg, pc_valido_next;
  logic [31:0]          ult_end_reg, ult_end_next;
  logic [31:0]          raw_reg, raw_next;
  logic                 sgn_reg, sgn_next;
  logic                 ovf_reg, ovf_next;
  logic [BITS_CONV-1:0] sr_reg, sr_next;
  logic [BCD_W-1:0]     bcd_reg, bcd_next;
  logic [CNT_W-1:0]     cnt_reg, cnt_next;

  logic [BCD_W-1:0]     segmentos_reg, segmentos_next;
  logic [BCD_W-1:0]     seg_prog_reg, seg_prog_next;
  logic [31:0]          saida_reg, saida_next;
  logic                 neg_reg, neg_next;
  logic                 estouro_reg, estouro_next;
  logic                 est_prog_reg, est_prog_next;
  logic                 pronto_reg, pronto_next;

  logic                 pend_pc;
  logic                 granted;
  fonte_t               fonte_sel;
  logic [31:0]          x_sel;
  logic                 neg_sel;
  logic [31:0]          mag;
  logic [BCD_W-1:0]     bcd_ajust;
  logic [BCD_W-1:0]     resultado;

  // PC request is a pure comparison, recomputed every cycle
  assign pend_pc = !pc_valido_reg || (endereco != ult_end_reg);

  // Double-dabble correction: every nibble >= 5 gets +3 before the shift
  genvar gi;
  generate
    for (gi = 0; gi < DIGITOS; gi++) begin : g_dabble
      assign bcd_ajust[4*gi +: 4] = (bcd_reg[4*gi +: 4] >= 4'd5) ?
                                    bcd_reg[4*gi +: 4] + 4'd3 :
                                    bcd_reg[4*gi +: 4];
    end
  endgenerate

  assign resultado = ovf_reg ? {BCD_W{1'b1}} : bcd_reg;

  always_comb begin
    state_next     = state_reg;
    fonte_next     = fonte_reg;
    pend_out_next  = pend_out_reg;
    pend_in_next   = pend_in_reg;
    op_out_next    = op_out_reg;
    op_in_next     = op_in_reg;
    pc_valido_next = pc_valido_reg;
    ult_end_next   = ult_end_reg;
    raw_next       = raw_reg;
    sgn_next       = sgn_reg;
    ovf_next       = ovf_reg;
    sr_next        = sr_reg;
    bcd_next       = bcd_reg;
    cnt_next       = cnt_reg;
    segmentos_next = segmentos_reg;
    seg_prog_next  = seg_prog_reg;
    saida_next     = saida_reg;
    neg_next       = neg_reg;
    estouro_next   = estouro_reg;
    est_prog_next  = est_prog_reg;
    pronto_next    = 1'b0;
    granted        = 1'b0;
    fonte_sel      = SRC_OUT;
    x_sel          = 32'd0;
    neg_sel        = 1'b0;
    mag            = 32'd0;

    case (state_reg)
      OCIOSO: begin
        if (pend_out_reg) begin
          granted       = 1'b1;
          fonte_sel     = SRC_OUT;
          x_sel         = op_out_reg;
          pend_out_next = 1'b0;
        end else if (pend_in_reg) begin
          granted      = 1'b1;
          fonte_sel    = SRC_IN;
          x_sel        = op_in_reg;
          pend_in_next = 1'b0;
        end else if (pend_pc) begin
          granted        = 1'b1;
          fonte_sel      = SRC_PC;
          x_sel          = endereco;
          ult_end_next   = endereco;
          pc_valido_next = 1'b1;
        end

        if (granted) begin
          // Only the OUT operand is signed
          neg_sel    = (fonte_sel == SRC_OUT) && x_sel[31];
          mag        = neg_sel ? (~x_sel + 32'd1) : x_sel;
          fonte_next = fonte_sel;
          raw_next   = x_sel;
          sgn_next   = neg_sel;
          if (mag > LIMITE) begin
            ovf_next   = 1'b1;
            state_next = GRAVA;
          end else begin
            ovf_next   = 1'b0;
            sr_next    = mag[BITS_CONV-1:0];
            bcd_next   = '0;
            cnt_next   = '0;
            state_next = CONVERTE;
          end
        end
      end

      CONVERTE: begin
        {bcd_next, sr_next} = {bcd_ajust, sr_reg} << 1;
        cnt_next = cnt_reg + 1'b1;
        if (cnt_reg == CNT_W'(BITS_CONV - 1)) begin
          state_next = GRAVA;
        end
      end

      GRAVA: begin
        if (fonte_reg == SRC_PC) begin
          seg_prog_next = resultado;
          est_prog_next = ovf_reg;
        end else begin
          segmentos_next = resultado;
          saida_next     = raw_reg;
          neg_next       = sgn_reg;
          estouro_next   = ovf_reg;
        end
        pronto_next = 1'b1;
        state_next  = OCIOSO;
      end

      default: state_next = OCIOSO;
    endcase

    // A new pulse wins over the clear of a same-edge grant; latest operand wins
    if (out) begin
      pend_out_next = 1'b1;
      op_out_next   = dados;
    end
    if (in) begin
      pend_in_next = 1'b1;
      op_in_next   = entrada;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg     <= OCIOSO;
      fonte_reg     <= SRC_OUT;
      pend_out_reg  <= 1'b0;
      pend_in_reg   <= 1'b0;
      op_out_reg    <= 32'd0;
      op_in_reg     <= 32'd0;
      pc_valido_reg <= 1'b0;
      ult_end_reg   <= 32'd0;
      raw_reg       <= 32'd0;
      sgn_reg       <= 1'b0;
      ovf_reg       <= 1'b0;
      sr_reg        <= '0;
      bcd_reg       <= '0;
      cnt_reg       <= '0;
      segmentos_reg <= '0;
      seg_prog_reg  <= '0;
      saida_reg     <= 32'd0;
      neg_reg       <= 1'b0;
      estouro_reg   <= 1'b0;
      est_prog_reg  <= 1'b0;
      pronto_reg    <= 1'b0;
    end else begin
      state_reg     <= state_next;
      fonte_reg     <= fonte_next;
      pend_out_reg  <= pend_out_next;
      pend_in_reg   <= pend_in_next;
      op_out_reg    <= op_out_next;
      op_in_reg     <= op_in_next;
      pc_valido_reg <= pc_valido_next;
      ult_end_reg   <= ult_end_next;
      raw_reg       <= raw_next;
      sgn_reg       <= sgn_next;
      ovf_reg       <= ovf_next;
      sr_reg        <= sr_next;
      bcd_reg       <= bcd_next;
      cnt_reg       <= cnt_next;
      segmentos_reg <= segmentos_next;
      seg_prog_reg  <= seg_prog_next;
      saida_reg     <= saida_next;
      neg_reg       <= neg_next;
      estouro_reg   <= estouro_next;
      est_prog_reg  <= est_prog_next;
      pronto_reg    <= pronto_next;
    end
  end

  assign segmentos         = segmentos_reg;
  assign segmentosPrograma = seg_prog_reg;
  assign saida             = saida_reg;
  assign neg               = neg_reg;
  assign estouro           = estouro_reg;
  assign estouroPrograma   = est_prog_reg;
  assign ocupado           = (state_reg != OCIOSO);
  assign pronto            = pronto_reg;

endmodule

// File: tb/tb_controle_display.sv
// Bench for controle_display: transaction-level reference model compared every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_controle_display;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        out = 1'b0;
  logic        in = 1'b0;
  logic [31:0] dados = 32'd0;
  logic [31:0] entrada = 32'd0;
  logic [31:0] endereco = 32'd0;
  logic [31:0] segmentos, segmentosPrograma, saida;
  logic        neg, estouro, estouroPrograma, ocupado, pronto;

  int checks = 0;
  int errors = 0;

  controle_display dut (
    .clock(clock), .reset(reset), .out(out), .in(in),
    .dados(dados), .entrada(entrada), .endereco(endereco),
    .segmentos(segmentos), .segmentosPrograma(segmentosPrograma),
    .saida(saida), .neg(neg), .estouro(estouro),
    .estouroPrograma(estouroPrograma), .ocupado(ocupado), .pronto(pronto)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Decimal digits by plain division, independent of any shift algorithm
  function automatic logic [31:0] to_bcd(input logic [31:0] v);
    logic [31:0] r;
    logic [31:0] t;
    r = 32'd0;
    t = v;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // Reference model: pending requests plus a countdown to the write edge
  bit          m_armed = 0;
  bit          m_pend_out, m_pend_in, m_pc_valid;
  logic [31:0] m_op_out, m_op_in, m_last_pc;
  int          m_timer, m_src;
  logic [31:0] m_raw, m_res, m_mag;
  bit          m_sgn, m_ovf;
  logic [31:0] m_seg, m_segp, m_saida;
  bit          m_neg, m_est, m_estp, m_pronto;

  always @(posedge clock) begin
    if (reset) begin
      m_armed = 1; m_pend_out = 0; m_pend_in = 0; m_pc_valid = 0;
      m_op_out = 0; m_op_in = 0; m_last_pc = 0; m_timer = 0; m_src = 0;
      m_seg = 0; m_segp = 0; m_saida = 0; m_neg = 0; m_est = 0; m_estp = 0;
      m_pronto = 0;
    end else if (m_armed) begin
      m_pronto = 0;
      if (m_timer > 0) begin
        m_timer--;
        if (m_timer == 0) begin
          if (m_src == 2) begin
            m_segp = m_res; m_estp = m_ovf;
          end else begin
            m_seg = m_res; m_saida = m_raw; m_neg = m_sgn; m_est = m_ovf;
          end
          m_pronto = 1;
          $display("txn src=%0d raw=%h bcd=%h sgn=%0d ovf=%0d", m_src, m_raw, m_res, m_sgn, m_ovf);
        end
      end else if (m_pend_out || m_pend_in || !m_pc_valid || endereco != m_last_pc) begin
        if (m_pend_out) begin
          m_src = 0; m_raw = m_op_out; m_pend_out = 0;
        end else if (m_pend_in) begin
          m_src = 1; m_raw = m_op_in; m_pend_in = 0;
        end else begin
          m_src = 2; m_raw = endereco; m_last_pc = endereco; m_pc_valid = 1;
        end
        m_sgn   = (m_src == 0) && m_raw[31];
        m_mag   = m_sgn ? (32'd0 - m_raw) : m_raw;
        m_ovf   = (m_mag > 32'd99_999_999);
        m_res   = m_ovf ? 32'hFFFF_FFFF : to_bcd(m_mag);
        m_timer = m_ovf ? 1 : 28;
      end
      if (out) begin m_pend_out = 1; m_op_out = dados; end
      if (in)  begin m_pend_in = 1;  m_op_in = entrada; end
    end
  end

  always @(negedge clock) begin
    if (m_armed) begin
      check("m_segmentos", segmentos, m_seg);
      check("m_segmentosPrograma", segmentosPrograma, m_segp);
      check("m_saida", saida, m_saida);
      check("m_neg", 32'(neg), 32'(m_neg));
      check("m_estouro", 32'(estouro), 32'(m_est));
      check("m_estouroPrograma", 32'(estouroPrograma), 32'(m_estp));
      check("m_ocupado", 32'(ocupado), 32'(m_timer > 0));
      check("m_pronto", 32'(pronto), 32'(m_pronto));
    end
  end

  // n counts negedges since the pulse was driven; n=k is just after edge E(k-1)
  task automatic run_until_pronto(input int max, inout int n, output bit ok);
    ok = 0;
    while (n < max) begin
      @(negedge clock);
      n++;
      out = 1'b0;
      in  = 1'b0;
      if (pronto) begin
        ok = 1;
        return;
      end
    end
  endtask

  function automatic logic [31:0] rand_val(input bit signed_ok);
    logic [31:0] v;
    case ($urandom_range(0, 6))
      0: v = $urandom_range(0, 9999);
      1: v = signed_ok ? 32'd0 - $urandom_range(0, 9999) : $urandom_range(0, 99);
      2: v = $urandom;
      3: v = 32'd99_999_999;
      4: v = 32'd100_000_000;
      5: v = signed_ok ? 32'd0 - 32'd99_999_999 : 32'd0;
      default: v = $urandom_range(0, 99_999_999);
    endcase
    return v;
  endfunction

  initial begin
    int n;
    bit ok;

    @(negedge clock);
    @(negedge clock);
    check("reset_segmentos", segmentos, 32'd0);
    check("reset_segmentosPrograma", segmentosPrograma, 32'd0);
    check("reset_ocupado", 32'(ocupado), 32'd0);
    check("reset_pronto", 32'(pronto), 32'd0);
    reset = 1'b0;
    repeat (40) @(negedge clock);

    // out 1234
    out = 1'b1; dados = 32'd1234; n = 0;
    run_until_pronto(100, n, ok);
    check("t1_done", 32'(ok), 32'd1);
    check("t1_latency", n, 32'd30);
    check("t1_segmentos", segmentos, 32'h0000_1234);
    check("t1_saida", saida, 32'd1234);
    check("t1_neg", 32'(neg), 32'd0);
    check("t1_estouro", 32'(estouro), 32'd0);
    repeat (3) @(negedge clock);

    // out -45
    out = 1'b1; dados = 32'hFFFF_FFD3; n = 0;
    run_until_pronto(100, n, ok);
    check("t2_latency", n, 32'd30);
    check("t2_segmentos", segmentos, 32'h0000_0045);
    check("t2_neg", 32'(neg), 32'd1);
    check("t2_saida", saida, 32'hFFFF_FFD3);
    repeat (3) @(negedge clock);

    // simultaneous out and in
    out = 1'b1; dados = 32'd7; in = 1'b1; entrada = 32'd99_999_999; n = 0;
    run_until_pronto(100, n, ok);
    check("t3a_latency", n, 32'd30);
    check("t3a_segmentos", segmentos, 32'h0000_0007);
    run_until_pronto(100, n, ok);
    check("t3b_latency", n, 32'd59);
    check("t3b_segmentos", segmentos, 32'h9999_9999);
    check("t3b_saida", saida, 32'd99_999_999);
    repeat (3) @(negedge clock);

    // overflow paths
    in = 1'b1; entrada = 32'd100_000_000; n = 0;
    run_until_pronto(100, n, ok);
    check("t4a_latency", n, 32'd3);
    check("t4a_estouro", 32'(estouro), 32'd1);
    check("t4a_segmentos", segmentos, 32'hFFFF_FFFF);
    repeat (3) @(negedge clock);
    out = 1'b1; dados = 32'h8000_0000; n = 0;
    run_until_pronto(100, n, ok);
    check("t4b_latency", n, 32'd3);
    check("t4b_estouro", 32'(estouro), 32'd1);
    check("t4b_neg", 32'(neg), 32'd1);
    check("t4b_saida", saida, 32'h8000_0000);
    repeat (3) @(negedge clock);

    // PC change while an out request is pending
    out = 1'b1; dados = 32'd4321;
    @(negedge clock);
    out = 1'b0; endereco = 32'd63; n = 1;
    run_until_pronto(100, n, ok);
    check("t5a_latency", n, 32'd30);
    check("t5a_segmentos", segmentos, 32'h0000_4321);
    check("t5a_segmentosPrograma", segmentosPrograma, 32'd0);
    run_until_pronto(100, n, ok);
    check("t5b_latency", n, 32'd59);
    check("t5b_segmentosPrograma", segmentosPrograma, 32'h0000_0063);
    check("t5b_segmentos", segmentos, 32'h0000_4321);
    repeat (3) @(negedge clock);

    // reset at E15 of a conversion
    out = 1'b1; dados = 32'd555; n = 0;
    while (n < 15) begin
      @(negedge clock);
      n++;
      out = 1'b0;
    end
    reset = 1'b1; endereco = 32'd5;
    @(negedge clock);
    check("t6_segmentos", segmentos, 32'd0);
    check("t6_saida", saida, 32'd0);
    check("t6_neg", 32'(neg), 32'd0);
    check("t6_ocupado", 32'(ocupado), 32'd0);
    check("t6_pronto", 32'(pronto), 32'd0);
    reset = 1'b0; n = 0;
    run_until_pronto(100, n, ok);
    check("t6_latency", n, 32'd29);
    check("t6_segmentosPrograma", segmentosPrograma, 32'h0000_0005);
    check("t6_segmentos_kept", segmentos, 32'd0);

    // random traffic
    for (int c = 0; c < 4000; c++) begin
      @(negedge clock);
      out     = ($urandom_range(0, 19) == 0);
      dados   = rand_val(1'b1);
      in      = ($urandom_range(0, 24) == 0);
      entrada = rand_val(1'b0);
      if ($urandom_range(0, 59) == 0)
        endereco = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF0 : $urandom_range(0, 200);
      reset   = ($urandom_range(0, 1999) == 0);
    end
    @(negedge clock);
    out = 1'b0; in = 1'b0; reset = 1'b0;
    repeat (120) @(negedge clock);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
